// File: rtl/var_seq_pkg.sv
// rtl/var_seq_pkg.sv - shared types and defaults for the variable update sequencer
// Holds the FSM state enum, the queue entry struct {addr,data}, the ADDR_MAX and
// FIFO_DEPTH defaults, and the address-range helper.
// The VERIFY state exists only when VARSEQ_VERIFY_EN is defined.
package var_seq_pkg;

    localparam int ADDR_MAX_DEFAULT   = 43;
    localparam int FIFO_DEPTH_DEFAULT = 8;

`ifdef VARSEQ_VERIFY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_VERIFY = 2'd3
    } seq_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } q_entry_t;

    // Valid variable addresses are 1..addr_max; 0 is reserved.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_max);
        return (addr != 32'd0) && (addr <= addr_max);
    endfunction

endpackage

// File: rtl/var_update_sequencer_if.sv
// rtl/var_update_sequencer_if.sv - requester access port (host or auto-exposure)
// Signals: req/we/addr/wdata from the requester, ack (one-cycle grant pulse) and
// rdata (valid with ack) back to it.
// master = requester side, slave = sequencer side.
interface var_update_sequencer_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/var_seq_fifo.sv
// rtl/var_seq_fifo.sv - synchronous pending-write queue of {addr,data} entries
// Ports: clk, rst_n (async active-low), push/din, pop/dout (dout is the head entry),
// full, empty, count (occupancy 0..DEPTH). DEPTH must be a power of 2 so the
// pointers wrap naturally.
module var_seq_fifo
    import var_seq_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  q_entry_t                 din,
    input  logic                     pop,
    output q_entry_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    q_entry_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/var_update_sequencer.sv
// rtl/var_update_sequencer.sv - arbitrates host/AE variable accesses, queues writes, drains them in blanking
// Ports: clk, rst_n (async active-low); host, ae (requester ports, slave modport);
// frame_idle (blanking window); bank_wr_en/bank_addr/bank_wdata, bank_rdata (variable bank);
// pending (queue occupancy), addr_err (sticky bad address), verify_err (sticky readback mismatch).
// Macro VARSEQ_VERIFY_EN adds a readback VERIFY cycle after every drained write.
module var_update_sequencer
    import var_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int ADDR_MAX   = ADDR_MAX_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    var_update_sequencer_if.slave         host,
    var_update_sequencer_if.slave         ae,
    input  logic                          frame_idle,
    output logic                          bank_wr_en,
    output logic [31:0]                   bank_addr,
    output logic [31:0]                   bank_wdata,
    input  logic [31:0]                   bank_rdata,
    output logic [5:0]                    pending,
    output logic                          addr_err,
    output logic                          verify_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t     state_q, state_d;
    q_entry_t       head;
    logic           fifo_full, fifo_empty, push;
    logic [CW-1:0]  fifo_count;

    logic           rr_ae_q;      // 1: ae has priority at the next contention
    logic           rd_ae_q;      // requester owning the read in flight
    logic           host_ack_q, ae_ack_q;
    logic [31:0]    host_rdata_q, ae_rdata_q;
    logic [31:0]    bank_addr_q, bank_wdata_q;
    logic           addr_err_q;

    logic           host_valid, ae_valid, host_ok, ae_ok;
    logic           gnt_host, gnt_ae, g_gnt, g_we, g_valid, wr_active;
    logic [31:0]    g_addr, g_wdata;

    assign host_valid = addr_ok(host.addr, ADDR_MAX);
    assign ae_valid   = addr_ok(ae.addr, ADDR_MAX);

    // A requester is not re-granted while its ack is on the wire, and a valid write
    // waits for queue space. Invalid writes never occupy the queue so they may proceed.
    assign host_ok = host.req && !host_ack_q && (!host.we || !fifo_full || !host_valid);
    assign ae_ok   = ae.req && !ae_ack_q && (!ae.we || !fifo_full || !ae_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        gnt_host  = 1'b0;
        gnt_ae    = 1'b0;
        wr_active = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Draining takes priority over any new grant.
                if (frame_idle && !fifo_empty) begin
                    state_d = ST_DRAIN;
                end else if (host_ok && (!rr_ae_q || !ae_ok)) begin
                    gnt_host = 1'b1;
                    if (!host.we && host_valid) state_d = ST_READ;
                end else if (ae_ok) begin
                    gnt_ae = 1'b1;
                    if (!ae.we && ae_valid) state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_IDLE;
            ST_DRAIN: begin
                if (frame_idle && !fifo_empty) begin
                    wr_active = 1'b1;
`ifdef VARSEQ_VERIFY_EN
                    state_d = ST_VERIFY;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef VARSEQ_VERIFY_EN
            ST_VERIFY: state_d = ST_DRAIN;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign g_gnt   = gnt_host || gnt_ae;
    assign g_we    = gnt_ae ? ae.we    : host.we;
    assign g_valid = gnt_ae ? ae_valid : host_valid;
    assign g_addr  = gnt_ae ? ae.addr  : host.addr;
    assign g_wdata = gnt_ae ? ae.wdata : host.wdata;
    assign push    = g_gnt && g_we && g_valid;

    var_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ('{addr: g_addr, data: g_wdata}),
        .pop   (wr_active),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The head entry goes straight onto the bank in the cycle it is popped; outside
    // those cycles the bank address holds whatever was last driven.
    assign bank_wr_en = wr_active;
    assign bank_addr  = wr_active ? head.addr : bank_addr_q;
    assign bank_wdata = wr_active ? head.data : bank_wdata_q;
    assign pending    = 6'(fifo_count);
    assign addr_err   = addr_err_q;
    assign host.ack   = host_ack_q;
    assign host.rdata = host_rdata_q;
    assign ae.ack     = ae_ack_q;
    assign ae.rdata   = ae_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ae_q      <= 1'b0;
            rd_ae_q      <= 1'b0;
            host_ack_q   <= 1'b0;
            ae_ack_q     <= 1'b0;
            host_rdata_q <= '0;
            ae_rdata_q   <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            ae_ack_q   <= 1'b0;
            if (g_gnt) begin
                rr_ae_q <= gnt_host;
                rd_ae_q <= gnt_ae;
                if (!g_valid) addr_err_q <= 1'b1;
                if (g_we || !g_valid) begin
                    // Writes and invalid reads complete without touching the bank.
                    host_ack_q <= gnt_host;
                    ae_ack_q   <= gnt_ae;
                    if (!g_we && gnt_host) host_rdata_q <= '0;
                    if (!g_we && gnt_ae)   ae_rdata_q   <= '0;
                end else begin
                    bank_addr_q <= g_addr;
                end
            end
            if (state_q == ST_READ) begin
                if (rd_ae_q) begin
                    ae_rdata_q <= bank_rdata;
                    ae_ack_q   <= 1'b1;
                end else begin
                    host_rdata_q <= bank_rdata;
                    host_ack_q   <= 1'b1;
                end
            end
            if (wr_active) begin
                bank_addr_q  <= head.addr;
                bank_wdata_q <= head.data;
            end
        end
    end

`ifdef VARSEQ_VERIFY_EN
    logic verify_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_err_q <= 1'b0;
        end else if (state_q == ST_VERIFY && bank_rdata != bank_wdata_q) begin
            verify_err_q <= 1'b1;
        end
    end
    assign verify_err = verify_err_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_var_update_sequencer.sv
// tb/tb_var_update_sequencer.sv - self-checking bench for var_update_sequencer
module tb_var_update_sequencer;

    localparam int AMAX = 43;

    logic        clk;
    logic        rst_n;
    logic        frame_idle;
    logic        bank_wr_en;
    logic [31:0] bank_addr, bank_wdata, bank_rdata;
    logic [5:0]  pending;
    logic        addr_err, verify_err;
    logic        force_mm;

    int tests_run    = 0;
    int tests_failed = 0;

    var_update_sequencer_if host_if ();
    var_update_sequencer_if ae_if ();

    var_update_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (host_if),
        .ae         (ae_if),
        .frame_idle (frame_idle),
        .bank_wr_en (bank_wr_en),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .pending    (pending),
        .addr_err   (addr_err),
        .verify_err (verify_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Variable bank: unwritten locations read as addr*16.
    logic [31:0] bank_mem [64];
    bit          bank_wr  [64];
    always @(posedge clk) begin
        if (bank_wr_en) begin
            bank_mem[bank_addr[5:0]] <= bank_wdata;
            bank_wr[bank_addr[5:0]]  <= 1'b1;
        end
    end
    assign bank_rdata = force_mm ? ~(bank_wr[bank_addr[5:0]] ? bank_mem[bank_addr[5:0]] : {bank_addr[27:0], 4'h0})
                                 :  (bank_wr[bank_addr[5:0]] ? bank_mem[bank_addr[5:0]] : {bank_addr[27:0], 4'h0});

    int          wr_pulses = 0;
    logic [31:0] last_wr_addr, last_wr_data;
    int          cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (bank_wr_en) begin
            wr_pulses++;
            last_wr_addr = bank_addr;
            last_wr_data = bank_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered list of accepted writes, expected bank contents,
    // sticky address-error flag and the order in which requesters were acked.
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    ent_t        mq [$];
    logic [31:0] shadow [64];
    bit          shadow_wr [64];
    bit          exp_addr_err = 0;
    int          ack_order [$];

    function automatic logic [31:0] exp_bank(input logic [31:0] a);
        return shadow_wr[a[5:0]] ? shadow[a[5:0]] : a * 32'd16;
    endfunction

    task automatic note_ack(input int who, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
        bit ok;
        ent_t e;
        ok = (a != 0) && (a <= AMAX);
        ack_order.push_back(who);
        if (!ok) exp_addr_err = 1;
        if (we && ok) begin
            e.addr = a;
            e.data = wd;
            mq.push_back(e);
        end
        if (!we) check_eq("rdata", rd, ok ? exp_bank(a) : 32'd0);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            exp_addr_err = 0;
        end else begin
            if (host_if.ack) note_ack(0, host_if.we, host_if.addr, host_if.wdata, host_if.rdata);
            if (ae_if.ack)   note_ack(1, ae_if.we, ae_if.addr, ae_if.wdata, ae_if.rdata);
            check_eq("pending", {26'd0, pending}, 32'(mq.size()));
            check_eq("addr_err", {31'd0, addr_err}, {31'd0, exp_addr_err});
            if (bank_wr_en) begin
                check_eq("wr_outside_blank", {31'd0, frame_idle}, 32'd1);
                if (mq.size() == 0) begin
                    check_eq("bank_unexpected_wr", 32'd1, 32'd0);
                end else begin
                    e = mq.pop_front();
                    check_eq("bank_addr", bank_addr, e.addr);
                    check_eq("bank_wdata", bank_wdata, e.data);
                    shadow[e.addr[5:0]]    = e.data;
                    shadow_wr[e.addr[5:0]] = 1'b1;
                end
            end
        end
    end

    task automatic access(input bit use_ae, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output bit got);
        got = 0;
        @(posedge clk); #1;
        if (use_ae) begin ae_if.req = 1; ae_if.we = we; ae_if.addr = a; ae_if.wdata = wd; end
        else begin host_if.req = 1; host_if.we = we; host_if.addr = a; host_if.wdata = wd; end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (use_ae ? ae_if.ack : host_if.ack) got = 1;
        end
        if (!got) check_eq(use_ae ? "ae_ack_timeout" : "host_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (use_ae) ae_if.req = 0; else host_if.req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; host_if.req = 0; ae_if.req = 0; frame_idle = 0; force_mm = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    bit rand_run, got, ninth_done;
    int base, n;
    int exp_order [4] = '{0, 1, 0, 1};

    initial begin
        rst_n = 0; frame_idle = 0; force_mm = 0;
        host_if.req = 0; host_if.we = 0; host_if.addr = 0; host_if.wdata = 0;
        ae_if.req = 0; ae_if.we = 0; ae_if.addr = 0; ae_if.wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check_eq("rst_pending", {26'd0, pending}, 32'd0);
        check_eq("rst_bank_wr_en", {31'd0, bank_wr_en}, 32'd0);
        check_eq("rst_bank_addr", bank_addr, 32'd0);
        check_eq("rst_bank_wdata", bank_wdata, 32'd0);
        check_eq("rst_host_ack", {31'd0, host_if.ack}, 32'd0);
        check_eq("rst_host_rdata", host_if.rdata, 32'd0);
        check_eq("rst_verify_err", {31'd0, verify_err}, 32'd0);

        // Read address 1 right after reset returns the bank's value (16).
        access(0, 0, 32'd1, 32'd0, got);
        check_eq("read_addr1", host_if.rdata, 32'd16);

        // Single write held until blanking, then exactly one bank pulse.
        access(0, 1, 32'd26, 32'd5000, got);
        check_eq("w26_pending", {26'd0, pending}, 32'd1);
        base = wr_pulses;
        repeat (5) @(negedge clk);
        check_eq("w26_no_wr_busy", 32'(wr_pulses - base), 32'd0);
        @(posedge clk); #1 frame_idle = 1;
        repeat (10) @(negedge clk);
        check_eq("w26_pulses", 32'(wr_pulses - base), 32'd1);
        check_eq("w26_addr", last_wr_addr, 32'd26);
        check_eq("w26_data", last_wr_data, 32'd5000);
        check_eq("w26_pending0", {26'd0, pending}, 32'd0);

        // Simultaneous writers alternate host, ae, host, ae from reset.
        do_reset();
        ack_order.delete();
        fork
            begin access(0, 1, 32'd2, 32'd100, got); access(0, 1, 32'd3, 32'd101, got); end
            begin bit g2; access(1, 1, 32'd4, 32'd200, g2); access(1, 1, 32'd5, 32'd201, g2); end
        join
        check_eq("rr_count", 32'(ack_order.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_order.size(); i++) check_eq("rr_order", 32'(ack_order[i]), 32'(exp_order[i]));

        // Full queue blocks the ninth write until blanking drains.
        do_reset();
        for (int i = 1; i <= 8; i++) access(0, 1, 32'(i), 32'(1000 + i), got);
        check_eq("full_pending", {26'd0, pending}, 32'd8);
        ninth_done = 0;
        fork
            begin bit g3; access(0, 1, 32'd9, 32'd1009, g3); ninth_done = g3; end
        join_none
        repeat (20) @(negedge clk);
        check_eq("full_no_ack", {31'd0, ninth_done}, 32'd0);
        base = wr_pulses;
        @(posedge clk); #1 frame_idle = 1;
        for (n = 0; n < 200 && !ninth_done; n++) @(negedge clk);
        check_eq("full_ninth_acked", {31'd0, ninth_done}, 32'd1);
        check_eq("full_drained_first", 32'(wr_pulses - base >= 1), 32'd1);
        repeat (20) @(negedge clk);

        // Invalid read address.
        access(0, 0, 32'd44, 32'd0, got);
        check_eq("bad_read_rdata", host_if.rdata, 32'd0);
        check_eq("bad_read_err", {31'd0, addr_err}, 32'd1);

        // Blanking ends after 3 of 5 entries.
        do_reset();
        check_eq("rst_addr_err_clr", {31'd0, addr_err}, 32'd0);
        for (int i = 0; i < 5; i++) access(i[0], 1, 32'(10 + i), 32'(7000 + i), got);
        base = wr_pulses;
        @(posedge clk); #1 frame_idle = 1;
        for (n = 0; n < 100 && (wr_pulses - base + int'(bank_wr_en)) < 3; n++) @(negedge clk);
        @(posedge clk); #1 frame_idle = 0;
        repeat (6) @(negedge clk);
        check_eq("part_pulses", 32'(wr_pulses - base), 32'd3);
        check_eq("part_pending", {26'd0, pending}, 32'd2);
        @(posedge clk); #1 frame_idle = 1;
        repeat (12) @(negedge clk);
        check_eq("part_rest", 32'(wr_pulses - base), 32'd5);
        check_eq("part_pending0", {26'd0, pending}, 32'd0);

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 4; i++) access(0, 1, 32'(20 + i), 32'(300 + i), got);
        @(posedge clk); #1 frame_idle = 1;
        for (n = 0; n < 50 && !bank_wr_en; n++) @(negedge clk);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        check_eq("mid_rst_pending", {26'd0, pending}, 32'd0);
        check_eq("mid_rst_wr_en", {31'd0, bank_wr_en}, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        base = wr_pulses;
        repeat (10) @(negedge clk);
        check_eq("mid_rst_no_wr", 32'(wr_pulses - base), 32'd0);

        // Readback mismatch.
        do_reset();
        access(0, 1, 32'd5, 32'd77, got);
        force_mm = 1;
        @(posedge clk); #1 frame_idle = 1;
        repeat (10) @(negedge clk);
`ifdef VARSEQ_VERIFY_EN
        check_eq("verify_err_set", {31'd0, verify_err}, 32'd1);
`else
        check_eq("verify_err_tied", {31'd0, verify_err}, 32'd0);
`endif
        force_mm = 0;

        // Randomized traffic from both requesters with random blanking windows.
        do_reset();
        rand_run = 1;
        fork
            while (rand_run) begin
                @(posedge clk); #1 frame_idle = ($urandom_range(0, 2) == 0);
                repeat ($urandom_range(1, 10)) @(posedge clk);
            end
        join_none
        fork
            for (int i = 0; i < 120; i++) begin
                bit gh;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                access(0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 47)), $urandom, gh);
            end
            for (int i = 0; i < 120; i++) begin
                bit ga;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                access(1, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 47)), $urandom, ga);
            end
        join
        rand_run = 0;
        repeat (15) @(posedge clk);
        #1 frame_idle = 1;
        repeat (40) @(negedge clk);
        check_eq("rand_final_empty", 32'(mq.size()), 32'd0);
        check_eq("rand_verify_clean", {31'd0, verify_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
